fifo_stream_drain: RTL

//  Read-side controller for the synchronous FIFO. Pops words through the FIFO read port and

---
 rtl/fifo_pack.sv | 16 +
 rtl/drain_skid_buf.sv | 68 ++++++
 rtl/fifo_stream_drain.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_pack.sv
// Shared types and constants for the FIFO read-side stream drain.
//   FIFO_WIDTH     default data width of the FIFO and its stream side
//   SKID_DEPTH     entries in the drain skid buffer
//   drain_state_e  drain controller states
package fifo_pack;

   localparam int FIFO_WIDTH = 16;
   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } drain_state_e;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry skid buffer. Entry 0 is always the head, so the head word only
// moves on a pop (or on a push into an empty buffer), which keeps it stable
// while the consumer stalls.
// Ports:
//   clk, rst     clock, async active-high reset
//   i_push       write i_push_data at the tail
//   i_pop        drop the head entry
//   i_clear      empty the buffer (wins over push/pop)
//   i_push_data  word to store
//   o_occ        number of valid entries (0..2)
//   o_head       head entry
module drain_skid_buf
   import fifo_pack::*;
#(
   parameter int DATA_W = FIFO_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_push_data,
   output logic [1:0]        o_occ,
   output logic [DATA_W-1:0] o_head
);

   logic [1:0]        r_occ;
   logic [DATA_W-1:0] r_e0;
   logic [DATA_W-1:0] r_e1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= 2'd0;
         r_e0  <= '0;
         r_e1  <= '0;
      end else if (i_clear) begin
         r_occ <= 2'd0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_occ != 2'(SKID_DEPTH)) begin
                  if (r_occ == 2'd0) r_e0 <= i_push_data;
                  else               r_e1 <= i_push_data;
                  r_occ <= r_occ + 2'd1;
               end
            end
            2'b01: begin
               r_e0  <= r_e1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; the new word lands behind whatever remains
               if (r_occ == 2'd1) begin
                  r_e0 <= i_push_data;
               end else begin
                  r_e0 <= r_e1;
                  r_e1 <= i_push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_e0;

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side controller for the synchronous FIFO: pops words and presents them
// as a valid/ready stream at one word per cycle, with a flush that drains and
// discards everything.
// Optional feature macro: DRAIN_STATS_EN (word_cnt / underflow_err counters;
// both outputs read 0 when it is not defined).
// Ports:
//   clk, rst                         clock, async active-high reset
//   enable, flush                    stream enable, level flush request
//   fifo_rd_en / fifo_data_out       FIFO pop request / data (valid next cycle)
//   fifo_empty, fifo_underflow       FIFO status flags
//   m_valid, m_data, m_ready         output stream
//   busy, flush_done                 activity flag, flush completion pulse
//   underflow_err, word_cnt          statistics
module fifo_stream_drain
   import fifo_pack::*;
#(
   parameter int DATA_W = FIFO_WIDTH,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_data_out,
   input  logic              fifo_empty,
   input  logic              fifo_underflow,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              busy,
   output logic              flush_done,
   output logic              underflow_err,
   output logic [CNT_W-1:0]  word_cnt
);

   drain_state_e r_state;
   logic         r_inflight;
   logic [1:0]   w_occ;
   logic         w_pop;
   logic         w_push;
   logic         w_clear;
   logic         w_rd_en;
   logic         w_flush_exit;

   assign w_pop        = (w_occ != 2'd0) & m_ready;
   // Skid is emptied on the edge into FLUSH and held empty throughout it,
   // which also discards any word arriving from the FIFO meanwhile.
   assign w_clear      = flush | (r_state == FLUSH);
   assign w_push       = r_inflight & ~w_clear;
   assign w_flush_exit = (r_state == FLUSH) & ~flush & fifo_empty & ~r_inflight;

   // Request a word only if it will have a skid slot when it arrives.
   // enable gates new requests so that dropping it stops popping at once.
   always_comb begin
      w_rd_en = 1'b0;
      case (r_state)
         STREAM: w_rd_en = enable & ~fifo_empty &
                           (({1'b0, w_occ} + {2'b00, r_inflight}) <= (3'd1 + {2'b00, w_pop}));
         FLUSH:  w_rd_en = ~fifo_empty;
         default: w_rd_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         case (r_state)
            IDLE: begin
               if (flush)       r_state <= FLUSH;
               else if (enable) r_state <= STREAM;
            end
            STREAM: begin
               if (flush)                        r_state <= FLUSH;
               else if (!enable && !r_inflight)  r_state <= IDLE;
            end
            FLUSH: begin
               if (w_flush_exit) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   drain_skid_buf #(.DATA_W(DATA_W)) u_skid (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_clear     (w_clear),
      .i_push_data (fifo_data_out),
      .o_occ       (w_occ),
      .o_head      (m_data)
   );

   assign fifo_rd_en = w_rd_en;
   assign m_valid    = (w_occ != 2'd0);
   assign busy       = (r_state != IDLE) | (w_occ != 2'd0) | r_inflight;
   assign flush_done = w_flush_exit;

`ifdef DRAIN_STATS_EN
   logic [CNT_W-1:0] r_word_cnt;
   logic             r_underflow_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word_cnt      <= '0;
         r_underflow_err <= 1'b0;
      end else begin
         if (w_pop) r_word_cnt <= r_word_cnt + 1'b1;
         // underflow reported while our own pop is landing = we popped an empty FIFO
         if (fifo_underflow && r_inflight) r_underflow_err <= 1'b1;
      end
   end

   assign word_cnt      = r_word_cnt;
   assign underflow_err = r_underflow_err;
`else
   logic w_unused_underflow;
   assign w_unused_underflow = fifo_underflow;
   assign word_cnt           = '0;
   assign underflow_err      = 1'b0;
`endif

endmodule
